// File: rtl/control_sequencer.sv
// Fetch/decode/execute sequencer: program ROM, authoritative PC and datapath control word.
// Optional feature macro CTRL_ILLEGAL_TRAP_EN: opcode 101 traps into HALT with a sticky flag.
module control_sequencer #(
  parameter int unsigned PC_W  = 3,
  parameter int unsigned IW    = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_prog_we,
  input  logic [PC_W-1:0]  i_prog_addr,
  input  logic [IW-1:0]    i_prog_data,
  input  logic             i_start,
  input  logic             i_hold,
  input  logic             i_Zero,
  input  logic             i_Negative,
  input  logic [15:0]      i_jump_target,
  output logic             o_MemoryBus,
  output logic             o_MemoryData,
  output logic             o_ReadWrite,
  output logic             o_MemoryWrite,
  output logic             o_ProgramReg,
  output logic             o_Jump,
  output logic             o_Branch,
  output logic [3:0]       o_FunctionSelect,
  output logic [2:0]       o_DataReg_A,
  output logic [2:0]       o_AdderssReg_A,
  output logic [2:0]       o_AddressReg_B,
  output logic             o_cw_valid,
  output logic [PC_W-1:0]  o_pc,
  output logic             o_halted,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_retired
);

  localparam int unsigned RomDepth = 2 ** PC_W;

  localparam logic [2:0] OpAlu     = 3'b000;
  localparam logic [2:0] OpLoad    = 3'b001;
  localparam logic [2:0] OpStore   = 3'b010;
  localparam logic [2:0] OpHalt    = 3'b011;
  localparam logic [2:0] OpImm     = 3'b100;
  localparam logic [2:0] OpIllegal = 3'b101;
  localparam logic [2:0] OpBranch  = 3'b110;
  localparam logic [2:0] OpJump    = 3'b111;

  typedef enum logic [2:0] {StIdle, StFetch, StDecode, StExec, StHalt} state_e;

  state_e          r_state;
  logic [IW-1:0]   r_rom [RomDepth];
  logic [IW-1:0]   r_ir;
  logic [PC_W-1:0] r_pc;
  logic [CNT_W-1:0] r_retired;
  logic            r_halted;
  logic [6:0]      r_ctl;
  logic [3:0]      r_fs;
  logic [2:0]      r_da;
  logic [2:0]      r_aa;
  logic [2:0]      r_ba;
  logic            r_cw_valid;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic            r_illegal;
`endif

  logic [2:0]      w_op;
  logic [3:0]      w_fs;
  logic [2:0]      w_da;
  logic [2:0]      w_aa;
  logic [2:0]      w_ba;
  logic [6:0]      w_ctl;
  logic            w_valid;
  logic            w_fields;
  logic            w_stop;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic            w_trap;
`endif
  logic [PC_W-1:0] w_off;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_pc_next;
  logic            w_taken;
  logic            w_unused_jt;

  assign w_op = r_ir[15:13];
  assign w_fs = r_ir[12:9];
  assign w_da = r_ir[8:6];
  assign w_aa = r_ir[5:3];
  assign w_ba = r_ir[2:0];

  // Control bits packed as {MB, MD, RW, MW, PL, Jump, Branch}.
  always_comb begin
    w_ctl    = '0;
    w_valid  = 1'b1;
    w_fields = 1'b1;
    w_stop   = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    w_trap   = 1'b0;
`endif
    unique case (w_op)
      OpAlu:    w_ctl = 7'b0010000;
      OpLoad:   w_ctl = 7'b0110000;
      OpStore:  w_ctl = 7'b0001000;
      OpImm:    w_ctl = 7'b1010000;
      OpBranch: w_ctl = {6'b000010, w_fs[0]};
      OpJump:   w_ctl = 7'b0000110;
      OpHalt: begin
        w_valid  = 1'b0;
        w_fields = 1'b0;
        w_stop   = 1'b1;
      end
      OpIllegal: begin
        w_fields = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        w_valid  = 1'b0;
        w_stop   = 1'b1;
        w_trap   = 1'b1;
`endif
      end
    endcase
  end

  assign w_off       = PC_W'({{13{w_ba[2]}}, w_ba});
  assign w_pc_inc    = r_pc + PC_W'(1);
  assign w_taken     = w_fs[0] ? i_Negative : i_Zero;
  assign w_unused_jt = ^i_jump_target;

  always_comb begin
    w_pc_next = w_pc_inc;
    if (w_op == OpBranch && w_taken) begin
      w_pc_next = r_pc + w_off;
    end else if (w_op == OpJump) begin
      w_pc_next = i_jump_target[PC_W-1:0];
    end
  end

  // ROM is deliberately not reset; it is only writable while the sequencer is parked.
  always_ff @(posedge i_clk) begin
    if (!i_hold && i_prog_we && (r_state == StIdle || r_state == StHalt)) begin
      r_rom[i_prog_addr] <= i_prog_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_ir       <= '0;
      r_pc       <= '0;
      r_retired  <= '0;
      r_halted   <= 1'b0;
      r_ctl      <= '0;
      r_fs       <= '0;
      r_da       <= '0;
      r_aa       <= '0;
      r_ba       <= '0;
      r_cw_valid <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
      r_illegal  <= 1'b0;
`endif
    end else if (!i_hold) begin
      unique case (r_state)
        StIdle: begin
          if (i_start) r_state <= StFetch;
        end
        StHalt: begin
          if (i_start) begin
            r_state  <= StFetch;
            r_pc     <= '0;
            r_halted <= 1'b0;
          end
        end
        StFetch: begin
          r_ir    <= r_rom[r_pc];
          r_state <= StDecode;
        end
        StDecode: begin
          r_ctl      <= w_ctl;
          r_fs       <= w_fields ? w_fs : 4'd0;
          r_da       <= w_fields ? w_da : 3'd0;
          r_aa       <= w_fields ? w_aa : 3'd0;
          r_ba       <= w_fields ? w_ba : 3'd0;
          r_cw_valid <= w_valid;
          r_state    <= StExec;
        end
        StExec: begin
          r_ctl      <= '0;
          r_fs       <= '0;
          r_da       <= '0;
          r_aa       <= '0;
          r_ba       <= '0;
          r_cw_valid <= 1'b0;
          if (w_stop) begin
            r_state  <= StHalt;
            r_halted <= 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
            if (w_trap) r_illegal <= 1'b1;
`endif
          end else begin
            r_pc    <= w_pc_next;
            r_state <= StFetch;
            if (r_cw_valid) r_retired <= r_retired + CNT_W'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign {o_MemoryBus, o_MemoryData, o_ReadWrite, o_MemoryWrite,
          o_ProgramReg, o_Jump, o_Branch} = r_ctl;
  assign o_FunctionSelect = r_fs;
  assign o_DataReg_A      = r_da;
  assign o_AdderssReg_A   = r_aa;
  assign o_AddressReg_B   = r_ba;
  assign o_cw_valid       = r_cw_valid;
  assign o_pc             = r_pc;
  assign o_halted         = r_halted;
  assign o_retired        = r_retired;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign o_illegal        = r_illegal;
`else
  assign o_illegal        = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: a program-level model predicts each control word,
// a monitor pops and compares whenever cw_valid retires or HALT is entered.
module tb_control_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_prog_we;
  logic [2:0]  i_prog_addr;
  logic [15:0] i_prog_data;
  logic        i_start;
  logic        i_hold;
  logic        i_Zero;
  logic        i_Negative;
  logic [15:0] i_jump_target;
  logic        o_MemoryBus, o_MemoryData, o_ReadWrite, o_MemoryWrite;
  logic        o_ProgramReg, o_Jump, o_Branch;
  logic [3:0]  o_FunctionSelect;
  logic [2:0]  o_DataReg_A, o_AdderssReg_A, o_AddressReg_B;
  logic        o_cw_valid;
  logic [2:0]  o_pc;
  logic        o_halted;
  logic        o_illegal;
  logic [15:0] o_retired;

  control_sequencer #(.PC_W(3), .IW(16), .CNT_W(16)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_prog_we(i_prog_we), .i_prog_addr(i_prog_addr),
    .i_prog_data(i_prog_data), .i_start(i_start), .i_hold(i_hold), .i_Zero(i_Zero),
    .i_Negative(i_Negative), .i_jump_target(i_jump_target), .o_MemoryBus(o_MemoryBus),
    .o_MemoryData(o_MemoryData), .o_ReadWrite(o_ReadWrite), .o_MemoryWrite(o_MemoryWrite),
    .o_ProgramReg(o_ProgramReg), .o_Jump(o_Jump), .o_Branch(o_Branch),
    .o_FunctionSelect(o_FunctionSelect), .o_DataReg_A(o_DataReg_A),
    .o_AdderssReg_A(o_AdderssReg_A), .o_AddressReg_B(o_AddressReg_B),
    .o_cw_valid(o_cw_valid), .o_pc(o_pc), .o_halted(o_halted), .o_illegal(o_illegal),
    .o_retired(o_retired)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit         is_halt;
    int         pc;
    int         retired;
    logic [6:0] ctl;   // {MB, MD, RW, MW, PL, Jump, Branch}
    logic [12:0] fld;  // {FS, DA, AA, BA}
    bit         illegal;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_rom [8];
  int          m_pc, m_retired;
  bit          m_halted, m_illegal;
  bit          hold_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  wire [6:0]  dut_ctl = {o_MemoryBus, o_MemoryData, o_ReadWrite, o_MemoryWrite,
                         o_ProgramReg, o_Jump, o_Branch};
  wire [12:0] dut_fld = {o_FunctionSelect, o_DataReg_A, o_AdderssReg_A, o_AddressReg_B};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Program-level reference: walks the ROM image and queues what each instruction must show.
  task automatic model_run(input int n);
    int pc, off, nxt;
    logic [15:0] w;
    logic [2:0] op, ba;
    logic [3:0] fs;
    bit stop, trap;
    exp_t e;
    pc = m_pc;
    for (int k = 0; k < n; k++) begin
      w = m_rom[pc];
      op = w[15:13];
      fs = w[12:9];
      ba = w[2:0];
      e.is_halt = 1'b0; e.pc = pc; e.retired = m_retired;
      e.ctl = '0; e.fld = w[12:0]; e.illegal = 1'b0;
      nxt = (pc + 1) % 8;
      stop = 1'b0; trap = 1'b0;
      case (op)
        3'd0: e.ctl = 7'b0010000;
        3'd1: e.ctl = 7'b0110000;
        3'd2: e.ctl = 7'b0001000;
        3'd4: e.ctl = 7'b1010000;
        3'd6: begin
          e.ctl = {4'b0000, 1'b1, 1'b0, fs[0]};
          off = ba[2] ? int'(ba) - 8 : int'(ba);
          if (fs[0] ? i_Negative : i_Zero) nxt = (pc + off + 8) % 8;
        end
        3'd7: begin
          e.ctl = 7'b0000110;
          nxt = int'(i_jump_target[2:0]);
        end
        3'd3: stop = 1'b1;
        default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          stop = 1'b1;
          trap = 1'b1;
`else
          e.fld = '0;
`endif
        end
      endcase
      if (stop) begin
        m_illegal = m_illegal | trap;
        e.is_halt = 1'b1;
        e.illegal = m_illegal;
        exp_q.push_back(e);
        m_halted = 1'b1;
        m_pc = pc;
        return;
      end
      exp_q.push_back(e);
      m_retired = (m_retired + 1) % 65536;
      pc = nxt;
    end
    m_pc = pc;
  endtask

  task automatic do_reset();
    hold_en = 1'b0;
    i_rst = 1'b1;
    repeat (2) begin @(posedge i_clk); #1; end
    i_rst = 1'b0;
    exp_q.delete();
    m_pc = 0; m_retired = 0; m_halted = 1'b0; m_illegal = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cw_valid"}, 32'(o_cw_valid), 32'd0);
    chk({tag, "_ctl"},      32'(dut_ctl),    32'd0);
    chk({tag, "_fields"},   32'(dut_fld),    32'd0);
    chk({tag, "_pc"},       32'(o_pc),       32'd0);
    chk({tag, "_halted"},   32'(o_halted),   32'd0);
    chk({tag, "_illegal"},  32'(o_illegal),  32'd0);
    chk({tag, "_retired"},  32'(o_retired),  32'd0);
  endtask

  task automatic load_rom(input int a, input logic [15:0] d);
    @(posedge i_clk); #1;
    i_prog_we = 1'b1; i_prog_addr = 3'(a); i_prog_data = d;
    @(posedge i_clk); #1;
    i_prog_we = 1'b0;
    m_rom[a] = d;
  endtask

  task automatic fill(input logic [15:0] d);
    for (int i = 0; i < 8; i++) load_rom(i, d);
  endtask

  // Launch from IDLE or HALT, wait for the scoreboard to drain, check end state.
  // A run that does not halt is stopped by raising reset before the next fetch completes.
  task automatic run(input int n, input bit use_hold, input bit chk_lat,
                     input bit ws_en, input logic [15:0] ws_data);
    hold_en = 1'b0;
    repeat (2) begin @(posedge i_clk); #1; end
    if (m_halted) begin m_pc = 0; m_halted = 1'b0; end
    if (ws_en) m_rom[0] = ws_data;
    model_run(n);
    i_start = 1'b1;
    if (ws_en) begin i_prog_we = 1'b1; i_prog_addr = 3'd0; i_prog_data = ws_data; end
    @(posedge i_clk); #1;
    i_start = 1'b0; i_prog_we = 1'b0;
    hold_en = use_hold;
    if (chk_lat) begin
      @(posedge i_clk); #1; chk("latency_2nd_edge", 32'(o_cw_valid), 32'd0);
      @(posedge i_clk); #1; chk("latency_3rd_edge", 32'(o_cw_valid), 32'd1);
    end
    for (int c = 0; c < 4000; c++) begin
      if (exp_q.size() == 0) break;
      @(posedge i_clk); #1;
      // Writes while running must be ignored; only issued while HALT is still far off.
      i_prog_we   = (exp_q.size() >= 2) && ($urandom_range(0, 5) == 0);
      i_prog_addr = 3'($urandom);
      i_prog_data = 16'($urandom);
    end
    i_prog_we = 1'b0;
    hold_en = 1'b0;
    if (exp_q.size() != 0) begin
      n_checks++; n_errors++;
      $display("FAIL run_timeout: got %0d pending responses, required 0", exp_q.size());
      exp_q.delete();
    end
    if (!m_halted) chk("end_pc", 32'(o_pc), 32'(m_pc));
    chk("end_retired", 32'(o_retired), 32'(m_retired));
    chk("end_halted",  32'(o_halted),  32'(m_halted));
    if (!m_halted) i_rst = 1'b1;
  endtask

  initial begin
    i_hold = 1'b0;
    forever begin
      @(posedge i_clk); #1;
      i_hold = hold_en && ($urandom_range(0, 2) == 0);
    end
  end

  // Monitor: a control word retires on a cw_valid cycle not under hold.
  initial begin
    exp_t e;
    bit prev_h;
    prev_h = 1'b0;
    forever begin
      @(negedge i_clk);
      if (!i_rst) begin
        if (o_cw_valid && !i_hold) begin
          if (exp_q.size() == 0 || exp_q[0].is_halt) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_cw_valid: got cw_valid=1 at pc=%0d, required none", o_pc);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
          end else begin
            e = exp_q.pop_front();
            chk("cw_ctl",     32'(dut_ctl),   32'(e.ctl));
            chk("cw_fields",  32'(dut_fld),   32'(e.fld));
            chk("cw_pc",      32'(o_pc),      32'(e.pc));
            chk("cw_retired", 32'(o_retired), 32'(e.retired));
          end
        end
        if (o_halted && !prev_h) begin
          if (exp_q.size() == 0 || !exp_q[0].is_halt) begin
            n_checks++; n_errors++;
            $display("FAIL unexpected_halt: got halted=1 at pc=%0d, required running", o_pc);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
          end else begin
            e = exp_q.pop_front();
            chk("halt_illegal", 32'(o_illegal), 32'(e.illegal));
            chk("halt_retired", 32'(o_retired), 32'(e.retired));
          end
        end
      end
      prev_h = o_halted;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    i_rst = 1'b1; i_prog_we = 1'b0; i_prog_addr = '0; i_prog_data = '0;
    i_start = 1'b0; i_Zero = 1'b0; i_Negative = 1'b0; i_jump_target = '0;
    m_pc = 0; m_retired = 0; m_halted = 1'b0; m_illegal = 1'b0;
    do_reset();
    check_reset("reset");

    // Single ADD: DA=1 AA=2 BA=3, FS=0010.
    fill(16'h0453);
    run(1, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("add_pc", 32'(o_pc), 32'd1);
    chk("add_retired", 32'(o_retired), 32'd1);
    do_reset();

    // Branch at pc 4 with offset -2, on Zero then on Negative.
    fill(16'h0453);
    load_rom(4, 16'hC00E);
    i_Zero = 1'b1; i_Negative = 1'b0;
    run(5, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("bz_taken_pc", 32'(o_pc), 32'd2);
    do_reset();
    i_Zero = 1'b0; i_Negative = 1'b1;
    run(5, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("bz_not_taken_pc", 32'(o_pc), 32'd5);
    do_reset();
    load_rom(4, 16'hC20E);
    i_Zero = 1'b0; i_Negative = 1'b1;
    run(5, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("bn_taken_pc", 32'(o_pc), 32'd2);
    do_reset();
    i_Zero = 1'b1; i_Negative = 1'b0;
    run(5, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("bn_not_taken_pc", 32'(o_pc), 32'd5);
    do_reset();

    // PC wrap after pc 7, then an unconditional jump.
    fill(16'h0453);
    run(8, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("wrap_pc", 32'(o_pc), 32'd0);
    do_reset();
    load_rom(0, 16'hE000);
    i_jump_target = 16'h0006;
    run(1, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("jump_pc", 32'(o_pc), 32'd6);
    do_reset();

    // HALT holds with no control words; ROM writable there; restart from pc 0.
    fill(16'h0453);
    load_rom(2, 16'h6000);
    run(10, 1'b1, 1'b0, 1'b0, 16'h0);
    chk("halt_entered", 32'(o_halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk); #1;
      chk("halt_stays", 32'(o_halted), 32'd1);
    end
    load_rom(1, 16'h4123);
    run(10, 1'b0, 1'b1, 1'b1, 16'h8111);
    chk("restart_halted", 32'(o_halted), 32'd1);
    do_reset();

    // Opcode 101.
    fill(16'h0453);
    load_rom(1, 16'hA1FF);
    run(4, 1'b0, 1'b0, 1'b0, 16'h0);
`ifdef CTRL_ILLEGAL_TRAP_EN
    chk("op101_illegal", 32'(o_illegal), 32'd1);
    chk("op101_halted", 32'(o_halted), 32'd1);
`else
    chk("op101_illegal", 32'(o_illegal), 32'd0);
    chk("op101_pc", 32'(o_pc), 32'd4);
`endif
    do_reset();

    // Reset in the middle of the third EXECUTE cycle.
    fill(16'h0453);
    model_run(5);
    i_start = 1'b1;
    @(posedge i_clk); #1;
    i_start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100 && cnt < 3; c++) begin
      @(posedge i_clk); #1;
      if (o_cw_valid) cnt++;
    end
    chk("mid_exec_reached", 32'(cnt), 32'd3);
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    exp_q.delete();
    check_reset("mid_exec_rst");
    do_reset();

    // Randomized programs, status and hold.
    for (int r = 0; r < 14; r++) begin
      do_reset();
      for (int i = 0; i < 8; i++) begin
        logic [2:0] op;
        op = 3'($urandom_range(0, 7));
        if (op == 3'd3 && $urandom_range(0, 1) == 0) op = 3'd0;
        load_rom(i, {op, 13'($urandom)});
      end
      i_Zero = 1'($urandom); i_Negative = 1'($urandom); i_jump_target = 16'($urandom);
      run($urandom_range(1, 16), 1'b1, 1'b0, 1'b0, 16'h0);
      if (m_halted) begin
        i_Zero = 1'($urandom); i_Negative = 1'($urandom);
        run($urandom_range(1, 8), 1'b1, 1'b0, 1'b1, 16'($urandom));
      end
    end
    do_reset();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
